// File: rtl/r3_poly_add_ctrl_if.sv
// r3_poly_add_ctrl_if: start/status, f/g/h RAM and trit-combine signals of r3_poly_add_ctrl
interface r3_poly_add_ctrl_if #(
    parameter int LANES = 4,
    parameter int AW    = 8
);
    logic               start;
    logic               busy;
    logic               done;
    logic [AW-1:0]      f_addr;
    logic [AW-1:0]      g_addr;
    logic [2*LANES-1:0] f_rdata;
    logic [2*LANES-1:0] g_rdata;
    logic [LANES-1:0]   comb_f0;
    logic [LANES-1:0]   comb_f1;
    logic [LANES-1:0]   comb_g0;
    logic [LANES-1:0]   comb_g1;
    logic [LANES-1:0]   comb_c0;
    logic [LANES-1:0]   comb_c1;
    logic [AW-1:0]      h_addr;
    logic [2*LANES-1:0] h_wdata;
    logic               h_we;

    modport master (
        input  start, f_rdata, g_rdata, comb_c0, comb_c1,
        output busy, done, f_addr, g_addr, comb_f0, comb_f1, comb_g0, comb_g1,
               h_addr, h_wdata, h_we
    );

    modport slave (
        output start, f_rdata, g_rdata, comb_c0, comb_c1,
        input  busy, done, f_addr, g_addr, comb_f0, comb_f1, comb_g0, comb_g1,
               h_addr, h_wdata, h_we
    );
endinterface

// File: rtl/r3_poly_add_ctrl.sv
// r3_poly_add_ctrl: streams packed R3 polynomials f,g through LANES combine cells into h; R3_ADD_TAILMASK_EN zeroes tail padding lanes
module r3_poly_add_ctrl #(
    parameter int P     = 761,
    parameter int LANES = 4,
    parameter int AW    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    r3_poly_add_ctrl_if.master bus
);
    localparam int W = (P + LANES - 1) / LANES;
    localparam logic [AW-1:0] LAST = AW'(W - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t             state_q, state_d;
    logic [AW-1:0]      rd_cnt_q, rd_cnt_d;
    logic [AW-1:0]      a1_q, a1_d;
    logic [AW-1:0]      h_addr_q, h_addr_d;
    logic [2*LANES-1:0] h_wdata_q, h_wdata_d;
    logic               drain_q, drain_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               v1_q, v1_d;
    logic               h_we_q, h_we_d;
    logic [LANES-1:0]   keep;

    // Lanes that carry real coefficients in the word currently in the data stage
    always_comb begin
        keep = '1;
`ifdef R3_ADD_TAILMASK_EN
        for (int i = 0; i < LANES; i++)
            keep[i] = !(a1_q == LAST && i >= P - (W - 1) * LANES);
`endif
    end

    // Data stage: unpack read words onto the combine cells, idle lanes at zero
    always_comb begin
        bus.comb_f0 = '0;
        bus.comb_f1 = '0;
        bus.comb_g0 = '0;
        bus.comb_g1 = '0;
        for (int i = 0; i < LANES; i++) begin
            bus.comb_f0[i] = v1_q & keep[i] & bus.f_rdata[2*i];
            bus.comb_f1[i] = v1_q & keep[i] & bus.f_rdata[2*i+1];
            bus.comb_g0[i] = v1_q & keep[i] & bus.g_rdata[2*i];
            bus.comb_g1[i] = v1_q & keep[i] & bus.g_rdata[2*i+1];
        end
    end

    // Next-state logic for the sequencer and the read/write pipeline
    always_comb begin
        state_d  = state_q;
        rd_cnt_d = rd_cnt_q;
        drain_d  = drain_q;
        case (state_q)
            IDLE: begin
                rd_cnt_d = '0;
                if (bus.start) state_d = RUN;
            end
            RUN: begin
                if (rd_cnt_q == LAST) begin
                    state_d = DRAIN;
                    drain_d = 1'b0;
                end else begin
                    rd_cnt_d = rd_cnt_q + 1'b1;
                end
            end
            DRAIN: begin
                drain_d = 1'b1;
                if (drain_q) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
        busy_d   = state_d == RUN || state_d == DRAIN;
        done_d   = state_d == DONE;
        v1_d     = state_q == RUN;
        a1_d     = rd_cnt_q;
        h_we_d   = v1_q;
        h_addr_d = a1_q;
        h_wdata_d = '0;
        for (int i = 0; i < LANES; i++) begin
            h_wdata_d[2*i]   = keep[i] & bus.comb_c0[i];
            h_wdata_d[2*i+1] = keep[i] & bus.comb_c1[i];
        end
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            rd_cnt_q  <= '0;
            drain_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            v1_q      <= 1'b0;
            a1_q      <= '0;
            h_we_q    <= 1'b0;
            h_addr_q  <= '0;
            h_wdata_q <= '0;
        end else begin
            state_q   <= state_d;
            rd_cnt_q  <= rd_cnt_d;
            drain_q   <= drain_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            v1_q      <= v1_d;
            a1_q      <= a1_d;
            h_we_q    <= h_we_d;
            h_addr_q  <= h_addr_d;
            h_wdata_q <= h_wdata_d;
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.f_addr  = rd_cnt_q;
    assign bus.g_addr  = rd_cnt_q;
    assign bus.h_we    = h_we_q;
    assign bus.h_addr  = h_addr_q;
    assign bus.h_wdata = h_wdata_q;
endmodule

// File: tb/tb_r3_poly_add_ctrl.sv
// tb_r3_poly_add_ctrl: directed vectors and timing sequences for r3_poly_add_ctrl
module tb_r3_poly_add_ctrl;
    typedef struct { int addr; logic [7:0] f; logic [7:0] g; logic [7:0] h; } vec_t;
    typedef struct { int cyc; int addr; logic [7:0] d; } wr_t;
    typedef struct { int cyc; logic [3:0] v; } f0_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int cyc = 0;
    int nvec = 0;
    int nerr = 0;
    logic [7:0] f_mem [256];
    logic [7:0] g_mem [256];
    wr_t wq[$];
    int dq[$];
    int dbusy[$];
    f0_t cq[$];

    r3_poly_add_ctrl_if #(.LANES(4), .AW(8)) bus();
    r3_poly_add_ctrl #(.P(761), .LANES(4), .AW(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.master));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // RAMs with one-cycle registered read
    always @(posedge clk) begin
        bus.f_rdata <= f_mem[bus.f_addr];
        bus.g_rdata <= g_mem[bus.g_addr];
    end

    // Trit model: 00=0, 01=+1, 10=-1 (x0 dominates), sum mod 3
    function automatic logic [1:0] tadd(input logic [1:0] a, input logic [1:0] b);
        int s;
        s = ((a[0] ? 1 : a[1] ? 2 : 0) + (b[0] ? 1 : b[1] ? 2 : 0)) % 3;
        return s == 1 ? 2'b01 : s == 2 ? 2'b10 : 2'b00;
    endfunction

    always_comb begin
        bus.comb_c0 = '0;
        bus.comb_c1 = '0;
        for (int i = 0; i < 4; i++)
            {bus.comb_c1[i], bus.comb_c0[i]} = tadd({bus.comb_f1[i], bus.comb_f0[i]}, {bus.comb_g1[i], bus.comb_g0[i]});
    end

    always @(negedge clk) begin
        if (bus.h_we) wq.push_back('{cyc, int'(bus.h_addr), bus.h_wdata});
        if (bus.done) begin
            dq.push_back(cyc);
            dbusy.push_back(int'(bus.busy));
        end
        if (bus.comb_f0 != 4'b0000) cq.push_back('{cyc, bus.comb_f0});
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic goto(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic kick(output int t0, output logic b1);
        wq.delete();
        dq.delete();
        dbusy.delete();
        cq.delete();
        bus.start = 1'b1;
        t0 = cyc;
        @(negedge clk);
        bus.start = 1'b0;
        b1 = bus.busy;
    endtask

    task automatic wait_done(input int n, input int lim);
        for (int i = 0; i < lim && dq.size() < n; i++) @(negedge clk);
        repeat (5) @(negedge clk);
    endtask

    task automatic check_writes(input string name, input int t0, input int n);
        int bad = 0;
        foreach (wq[i]) if (wq[i].addr != i || wq[i].cyc != t0 + i + 3) bad++;
        chk({name, "_wr_count"}, wq.size(), n);
        chk({name, "_wr_order"}, bad, 0);
    endtask

    task automatic check_done(input string name, input int t0);
        chk({name, "_done_count"}, dq.size(), 1);
        chk({name, "_done_cyc"}, dq.size() > 0 ? dq[0] - t0 : -1, 194);
        chk({name, "_busy_at_done"}, dbusy.size() > 0 ? dbusy[0] : -1, 0);
    endtask

    function automatic logic [31:0] wr_at(input int a);
        foreach (wq[i]) if (wq[i].addr == a) return {24'h0, wq[i].d};
        return 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] f0_at(input int c);
        foreach (cq[i]) if (cq[i].cyc == c) return {28'h0, cq[i].v};
        return 32'h0;
    endfunction

    initial begin
        vec_t tbl[8];
        int t0;
        int cnt;
        logic b1;
        logic [63:0] acc;
        tbl[0] = '{0,   8'h06, 8'h00, 8'h06};
        tbl[1] = '{5,   8'h01, 8'h00, 8'h01};
        tbl[2] = '{10,  8'h55, 8'h55, 8'hAA};
        tbl[3] = '{20,  8'hAA, 8'hAA, 8'h55};
        tbl[4] = '{30,  8'h55, 8'hAA, 8'h00};
        tbl[5] = '{40,  8'h91, 8'h58, 8'h29};
        tbl[6] = '{100, 8'h00, 8'h40, 8'h40};
`ifdef R3_ADD_TAILMASK_EN
        tbl[7] = '{190, 8'hFF, 8'hFF, 8'h02};
`else
        tbl[7] = '{190, 8'hFF, 8'hFF, 8'hAA};
`endif
        foreach (f_mem[i]) begin
            f_mem[i] = 8'h00;
            g_mem[i] = 8'h00;
        end

        // reset with start held high: reset must win
        bus.start = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_h_we", bus.h_we, 0);
        chk("rst_h_addr", bus.h_addr, 0);
        chk("rst_h_wdata", bus.h_wdata, 0);
        chk("rst_fg_addr", {bus.f_addr, bus.g_addr}, 0);
        chk("rst_comb", {bus.comb_f0, bus.comb_f1, bus.comb_g0, bus.comb_g1}, 0);
        rst_n = 1'b1;
        bus.start = 1'b0;
        acc = '0;
        repeat (20) begin
            @(negedge clk);
            acc |= {bus.busy, bus.done, bus.h_we, bus.h_addr, bus.h_wdata, bus.f_addr, bus.g_addr,
                    bus.comb_f0, bus.comb_f1, bus.comb_g0, bus.comb_g1};
        end
        chk("idle_outputs", acc[31:0] | acc[63:32], 0);

        // single run, all-zero operands
        kick(t0, b1);
        chk("zero_busy_c1", b1, 1);
        wait_done(1, 300);
        check_writes("zero", t0, 191);
        cnt = 0;
        foreach (wq[i]) if (wq[i].d != 8'h00) cnt++;
        chk("zero_wdata", cnt, 0);
        check_done("zero", t0);

        // table-driven operand vectors
        foreach (tbl[i]) begin
            f_mem[tbl[i].addr] = tbl[i].f;
            g_mem[tbl[i].addr] = tbl[i].g;
        end
        kick(t0, b1);
        wait_done(1, 300);
        check_writes("tbl", t0, 191);
        check_done("tbl", t0);
        foreach (tbl[i]) chk($sformatf("vec_h_addr%0d", tbl[i].addr), wr_at(tbl[i].addr), {24'h0, tbl[i].h});
        chk("lane_f0_c6", f0_at(t0 + 6), 0);
        chk("lane_f0_c7", f0_at(t0 + 7), 1);
        chk("lane_f0_c8", f0_at(t0 + 8), 0);
`ifdef R3_ADD_TAILMASK_EN
        chk("tail_f0_c192", f0_at(t0 + 192), 4'b0001);
`else
        chk("tail_f0_c192", f0_at(t0 + 192), 4'b1111);
`endif
        foreach (f_mem[i]) begin
            f_mem[i] = 8'h00;
            g_mem[i] = 8'h00;
        end

        // start while busy is ignored; start right after done is accepted
        kick(t0, b1);
        goto(t0 + 50);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        goto(t0 + 195);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(2, 400);
        chk("b2b_done_count", dq.size(), 2);
        chk("b2b_done0", dq.size() > 0 ? dq[0] - t0 : -1, 194);
        chk("b2b_done1", dq.size() > 1 ? dq[1] - t0 : -1, 389);

        // reset mid-run
        kick(t0, b1);
        goto(t0 + 100);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrst_h_we", bus.h_we, 0);
        chk("midrst_busy", bus.busy, 0);
        goto(t0 + 220);
        chk("midrst_no_done", dq.size(), 0);
        chk("midrst_wr_count", wq.size(), 98);
        cnt = 0;
        foreach (wq[i]) if (wq[i].cyc > t0 + 100) cnt++;
        chk("midrst_late_wr", cnt, 0);
        kick(t0, b1);
        wait_done(1, 300);
        check_writes("rerun", t0, 191);
        check_done("rerun", t0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/r3_poly_add_ctrl.md
# r3_poly_add_ctrl

Sequential controller that streams two packed R3 trit polynomials (f, g) out of word-organised RAMs through LANES parallel instances of the downstream combinational trit-combine stage and writes the combined result h back to a third RAM. It sits in the decapsulation datapath directly upstream of the trit-combine cells. It is their only source of f/g operands and their only consumer of c0/c1.

## Interface
Parameters:
- P, 761, polynomial length in coefficients
- LANES, 4, coefficients per RAM word
- AW, 8, RAM address width; must satisfy 2^AW >= W, where W = ceil(P/LANES) = 191 at defaults

Ports:
- clk  input  1  single clock; all logic on its rising edge
- rst_n  input  1  synchronous, active-low reset
- start  input  1  one-cycle request; sampled only in IDLE
- busy  output  1  high from the cycle after start is accepted until done
- done  output  1  one-cycle pulse after the last write
- f_addr, g_addr  output  AW  read addresses; RAMs have 1-cycle registered read latency
- f_rdata, g_rdata  input  2*LANES  lane i at bits [2i+1:2i]; bit 2i = x0, bit 2i+1 = x1
- comb_f0, comb_f1, comb_g0, comb_g1  output  LANES  per-lane operand bits to the combine cells
- comb_c0, comb_c1  input  LANES  per-lane combined result from the combine cells
- h_addr  output  AW  write address
- h_wdata  output  2*LANES  packed result, same lane layout as the inputs
- h_we  output  1  write strobe

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE: start=1 moves to RUN. The read counter rd_cnt is cleared to 0.
- RUN: f_addr = g_addr = rd_cnt, and rd_cnt increments every cycle. On issuing address W-1, the FSM moves to DRAIN.
- DRAIN: holds for exactly 2 cycles, which empties the read-data stage and the write stage. It then moves to DONE.
- DONE: done=1 for one cycle, busy=0, then the FSM returns to IDLE.
- Pipeline stage S1 (data cycle):
  - v1 and a1 are the one-cycle-delayed address-valid flag and address.
  - comb_* carry the unpacked rdata lanes when v1=1, and all zeros when v1=0.
- Pipeline stage S2 (write cycle):
  - The packed {c1,c0} per lane is registered into h_wdata, together with h_addr=a1 and h_we=v1.
- Tail word: address W-1 holds only P-(W-1)*LANES valid lanes, which is 1 at defaults. The remaining lanes are padding.
- start while busy=1 is ignored and has no side effects.
- No back-pressure exists: RAMs are always ready and there is exactly one write per read word.

## Timing
- Reset values: busy=0, done=0, h_we=0, h_addr=0, h_wdata=0, f_addr=g_addr=0, comb_*=0, FSM=IDLE.
- Cycle numbering, with start accepted at cycle 0:
  - cycle 1: RUN with address 0, busy=1
  - cycle 2: data for address 0 on comb_*
  - cycle 3: first h_we, with h_addr=0
- Address k is read in cycle k+1 and written in cycle k+3.
- Last write (address W-1) occurs in cycle W+2. done is pulsed in cycle W+3, and busy is low in that same cycle.
- Total latency from start to done is W+3 cycles, which is 194 at defaults.
- A new start is accepted in the cycle after done, i.e. back-to-back runs are spaced W+4 cycles apart.
- rst_n low in any cycle: the next edge forces all reset values, and h_we is low from that edge on. h contents are left partially written and are not restored.
- start and rst_n low in the same cycle: reset wins.
- W=1 (P<=LANES): RUN lasts one cycle, and the timing formulas above still hold.

## Configuration
- Macro: R3_ADD_TAILMASK_EN.
- Defined: padding lanes of the word at address W-1 are written as 2'b00 (zero trit), regardless of comb_c*. Padding lanes also drive comb_* = 0.
- Undefined: all lanes are treated uniformly, and padding lanes carry whatever the combine cells produce from the RAM contents. Software must then pre-zero the padding in f and g.

## Test plan
- Reset then idle: hold rst_n=0 for 3 cycles, release, keep start=0 for 20 cycles -> busy, done and h_we stay 0, and all outputs are 0.
- Single run at defaults, f=g=all 2'b00: start at cycle 0 -> exactly 191 writes at h_addr 0..190 in cycles 3..193, every h_wdata equal to the combine response to zero operands, done only at cycle 194.
- Lane ordering: f word 5 = 8'b00_00_00_01, all other f and g words 0 -> comb_f0=4'b0001 only in cycle 7, and h_addr=5 is written in cycle 8 with the model's lane-0 result.
- Tail mask: with R3_ADD_TAILMASK_EN defined and f/g word 190 = 8'hFF -> h_wdata[7:2]=0 at h_addr 190. With the macro undefined -> the model value is written in all 4 lanes.
- Start while busy: pulse start at cycles 0 and 50 -> only one run, done at cycle 194 only. A start at cycle 195 is accepted, and its done is at 389.
- Reset mid-run: rst_n=0 at cycle 100 -> h_we=0 from cycle 101, busy=0, no done. A fresh start afterwards completes normally in 194 cycles.
